// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: Q4.28 angle constants, range-reduction FSM states
// and the quarter-turn region encoding consumed by the CORDIC control FSM.
package cordic_pkg;

    localparam logic [31:0] HALF_PI       = 32'h1921FB54;
    localparam logic [31:0] PI            = 32'h3243F6A9;
    localparam logic [31:0] THREE_HALF_PI = 32'h4B65F1FD;
    localparam logic [31:0] TWO_PI        = 32'h6487ED51;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRAP     = 2'd1,
        ST_CLASSIFY = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REG_Q0 = 2'b00,
        REG_Q1 = 2'b01,
        REG_Q2 = 2'b10,
        REG_Q3 = 2'b11
    } region_t;

endpackage

// File: rtl/cordic_region_classify.sv
// Combinational quarter-turn classifier: maps an angle in [0, 2*pi) to its
// region and the offset from that region's lower bound.
module cordic_region_classify
    import cordic_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] i_acc,
    output region_t      o_region,
    output logic [W-1:0] o_angle_red
);

    localparam logic [W-1:0] HP  = W'(HALF_PI);
    localparam logic [W-1:0] P   = W'(PI);
    localparam logic [W-1:0] THP = W'(THREE_HALF_PI);

    logic [W-1:0] w_base;

    // Bounds belong to the upper region, so each test is >=.
    always_comb begin
        o_region = REG_Q0;
        w_base   = {W{1'b0}};
        if (i_acc >= THP) begin
            o_region = REG_Q3;
            w_base   = THP;
        end else if (i_acc >= P) begin
            o_region = REG_Q2;
            w_base   = P;
        end else if (i_acc >= HP) begin
            o_region = REG_Q1;
            w_base   = HP;
        end else begin
            o_region = REG_Q0;
            w_base   = {W{1'b0}};
        end
        o_angle_red = i_acc - w_base;
    end

endmodule

// File: rtl/cordic_range_reduction.sv
// Folds a signed Q4.28 angle into [0, 2*pi), then reports region and [0, pi/2)
// remainder. CORDIC_RANGE_RED_WRAP_EN enables iterative 2*pi correction.
module cordic_range_reduction
    import cordic_pkg::*;
#(
    parameter int W = 32
`ifdef CORDIC_RANGE_RED_WRAP_EN
    ,
    parameter int MAX_WRAP = 4
`endif
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         beg_range_red,
    input  logic         ack_range_red,
    input  logic [W-1:0] angle_in,
    output logic         ready_range_red,
    output logic         busy_range_red,
    output logic [1:0]   shift_region_flag,
    output logic [W-1:0] angle_red,
    output logic         range_error
);

    // One extra bit keeps acc +/- 2*pi free of overflow.
    localparam logic [W:0] TWO_PI_X = {{(W + 1 - 32){1'b0}}, TWO_PI};

    state_t       r_state;
    logic [W:0]   r_acc;
    logic         r_ready;
    logic         r_range_error;
    logic [1:0]   r_region;
    logic [W-1:0] r_angle_red;

    region_t      w_region;
    logic [W-1:0] w_angle_red;
    logic         w_out_of_range;

    assign w_out_of_range = r_acc[W] | (r_acc >= TWO_PI_X);

    cordic_region_classify #(.W(W)) u_classify (
        .i_acc       (r_acc[W-1:0]),
        .o_region    (w_region),
        .o_angle_red (w_angle_red)
    );

`ifdef CORDIC_RANGE_RED_WRAP_EN
    logic [3:0]   r_wrap_cnt;
    logic [W:0]   w_acc_wrapped;
    assign w_acc_wrapped = r_acc[W] ? (r_acc + TWO_PI_X) : (r_acc - TWO_PI_X);
`endif

    // Control FSM, accumulator and registered result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_acc         <= {(W + 1){1'b0}};
            r_ready       <= 1'b0;
            r_range_error <= 1'b0;
            r_region      <= 2'b00;
            r_angle_red   <= {W{1'b0}};
`ifdef CORDIC_RANGE_RED_WRAP_EN
            r_wrap_cnt    <= 4'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (beg_range_red) begin
                        r_acc         <= {angle_in[W-1], angle_in};
                        r_range_error <= 1'b0;
`ifdef CORDIC_RANGE_RED_WRAP_EN
                        r_wrap_cnt    <= 4'd0;
                        r_state       <= ST_WRAP;
`else
                        r_state       <= ST_CLASSIFY;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
`ifdef CORDIC_RANGE_RED_WRAP_EN
                ST_WRAP: begin
                    if (!w_out_of_range) begin
                        r_state <= ST_CLASSIFY;
                    end else if (r_wrap_cnt == 4'(MAX_WRAP)) begin
                        r_range_error <= 1'b1;
                        r_region      <= REG_Q0;
                        r_angle_red   <= {W{1'b0}};
                        r_state       <= ST_DONE;
                    end else begin
                        r_acc      <= w_acc_wrapped;
                        r_wrap_cnt <= r_wrap_cnt + 4'd1;
                    end
                end
                ST_CLASSIFY: begin
                    r_region    <= w_region;
                    r_angle_red <= w_angle_red;
                    r_state     <= ST_DONE;
                end
`else
                ST_CLASSIFY: begin
                    if (w_out_of_range) begin
                        r_range_error <= 1'b1;
                        r_region      <= REG_Q0;
                        r_angle_red   <= {W{1'b0}};
                    end else begin
                        r_region    <= w_region;
                        r_angle_red <= w_angle_red;
                    end
                    r_state <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    // ack only counts once the consumer has seen ready.
                    if (!r_ready) begin
                        r_ready <= 1'b1;
                    end else if (ack_range_red) begin
                        r_ready <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_range_red   = r_ready;
    assign busy_range_red    = (r_state != ST_IDLE);
    assign shift_region_flag = r_region;
    assign angle_red         = r_angle_red;
    assign range_error       = r_range_error;

endmodule

// File: tb/tb_cordic_range_reduction.sv
// Directed self-checking bench for cordic_range_reduction; expectations cover
// both settings of CORDIC_RANGE_RED_WRAP_EN.
module tb_cordic_range_reduction;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        beg = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] angle_in = 32'h0;
    logic        ready, busy, range_error;
    logic [1:0]  region;
    logic [31:0] angle_red;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cordic_range_reduction u_dut (
        .clk               (clk),
        .reset             (reset),
        .beg_range_red     (beg),
        .ack_range_red     (ack),
        .angle_in          (angle_in),
        .ready_range_red   (ready),
        .busy_range_red    (busy),
        .shift_region_flag (region),
        .angle_red         (angle_red),
        .range_error       (range_error)
    );

`ifdef CORDIC_RANGE_RED_WRAP_EN
    logic        ready1, busy1, range_error1;
    logic [1:0]  region1;
    logic [31:0] angle_red1;

    cordic_range_reduction #(.MAX_WRAP(1)) u_dut1 (
        .clk               (clk),
        .reset             (reset),
        .beg_range_red     (beg),
        .ack_range_red     (ack),
        .angle_in          (angle_in),
        .ready_range_red   (ready1),
        .busy_range_red    (busy1),
        .shift_region_flag (region1),
        .angle_red         (angle_red1),
        .range_error       (range_error1)
    );

    localparam int BASE_LAT = 3;
    localparam logic [1:0]  V_REG [10] = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd0, 2'd1};
    localparam logic [31:0] V_RED [10] = '{32'h08000000, 32'h06DE04AC, 32'h0921FB54, 32'h0, 32'h0,
                                           32'h0, 32'h0, 32'h0DA9E8A5, 32'h1921FB53, 32'h0256175A};
    localparam logic        V_ERR [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam int          V_LAT [10] = '{3, 3, 4, 3, 3, 3, 4, 5, 3, 4};
`else
    localparam int BASE_LAT = 2;
    localparam logic [1:0]  V_REG [10] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    localparam logic [31:0] V_RED [10] = '{32'h08000000, 32'h06DE04AC, 32'h0, 32'h0, 32'h0,
                                           32'h0, 32'h0, 32'h0, 32'h1921FB53, 32'h0};
    localparam logic        V_ERR [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam int          V_LAT [10] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
`endif
    localparam logic [31:0] V_ANG [10] = '{32'h08000000, 32'h20000000, 32'hF0000000, 32'h1921FB54,
                                           32'h3243F6A9, 32'h4B65F1FD, 32'h6487ED51, 32'h90000000,
                                           32'h1921FB53, 32'h7FFFFFFF};

    task automatic start(input logic [31:0] a);
        @(negedge clk);
        angle_in = a;
        beg = 1'b1;
        @(posedge clk);
        #1;
        beg = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (ready !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({ready, busy, region, angle_red, range_error} !== 37'h0) begin
            errors++;
            $display("FAIL reset_during: got rdy=%b busy=%b reg=%b ang=%h err=%b, expected all 0",
                     ready, busy, region, angle_red, range_error);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({ready, busy, region, angle_red, range_error} !== 37'h0) begin
            errors++;
            $display("FAIL reset_after: got rdy=%b busy=%b reg=%b ang=%h err=%b, expected all 0",
                     ready, busy, region, angle_red, range_error);
        end
    endtask

    task automatic test_vectors();
        int lat;
        for (int i = 0; i < 10; i++) begin
            start(V_ANG[i]);
            wait_ready(lat);
            checks++;
            if (lat !== V_LAT[i]) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, V_LAT[i]);
            end
            checks++;
            if (region !== V_REG[i]) begin
                errors++;
                $display("FAIL vec%0d_region: got %b expected %b", i, region, V_REG[i]);
            end
            checks++;
            if (angle_red !== V_RED[i]) begin
                errors++;
                $display("FAIL vec%0d_angle_red: got %h expected %h", i, angle_red, V_RED[i]);
            end
            checks++;
            if (range_error !== V_ERR[i]) begin
                errors++;
                $display("FAIL vec%0d_range_error: got %b expected %b", i, range_error, V_ERR[i]);
            end
`ifdef CORDIC_RANGE_RED_WRAP_EN
            checks++;
            if (i == 7) begin
                if ({ready1, range_error1, region1, angle_red1} !== {1'b1, 1'b1, 2'b00, 32'h0}) begin
                    errors++;
                    $display("FAIL vec%0d_maxwrap1: got rdy=%b err=%b reg=%b ang=%h expected 1 1 00 0",
                             i, ready1, range_error1, region1, angle_red1);
                end
            end else begin
                if ({ready1, range_error1, region1, angle_red1} !== {1'b1, 1'b0, V_REG[i], V_RED[i]}) begin
                    errors++;
                    $display("FAIL vec%0d_maxwrap1: got rdy=%b err=%b reg=%b ang=%h expected 1 0 %b %h",
                             i, ready1, range_error1, region1, angle_red1, V_REG[i], V_RED[i]);
                end
            end
`endif
            do_ack();
        end
    endtask

    task automatic test_beg_while_busy();
        int lat;
        start(32'h08000000);
        @(negedge clk);
        angle_in = 32'h20000000;
        beg = 1'b1;
        @(posedge clk);
        #1;
        beg = 1'b0;
        wait_ready(lat);
        checks++;
        if (lat + 1 !== BASE_LAT) begin
            errors++;
            $display("FAIL busy_beg_latency: got %0d expected %0d", lat + 1, BASE_LAT);
        end
        checks++;
        if ({region, angle_red} !== {2'b00, 32'h08000000}) begin
            errors++;
            $display("FAIL busy_beg_result: got reg=%b ang=%h expected 00 08000000", region, angle_red);
        end
    endtask

    task automatic test_ready_hold();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (ready !== 1'b1) begin
                errors++;
                $display("FAIL ready_hold%0d: got %b expected 1", c, ready);
            end
        end
    endtask

    task automatic test_beg_ack_together();
        @(negedge clk);
        angle_in = 32'h20000000;
        beg = 1'b1;
        ack = 1'b1;
        @(posedge clk);
        #1;
        beg = 1'b0;
        ack = 1'b0;
        checks++;
        if ({ready, busy} !== 2'b00) begin
            errors++;
            $display("FAIL ack_drop: got rdy=%b busy=%b expected 0 0", ready, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({busy, region, angle_red} !== {1'b0, 2'b00, 32'h08000000}) begin
            errors++;
            $display("FAIL beg_dropped_hold: got busy=%b reg=%b ang=%h expected 0 00 08000000",
                     busy, region, angle_red);
        end
    endtask

    task automatic test_reset_in_classify();
        int lat;
        start(32'h20000000);
        wait_ready(lat);
        do_ack();
        start(32'h08000000);
`ifdef CORDIC_RANGE_RED_WRAP_EN
        @(posedge clk);
        #1;
`endif
        checks++;
        if ({busy, region, angle_red} !== {1'b1, 2'b01, 32'h06DE04AC}) begin
            errors++;
            $display("FAIL pre_reset_state: got busy=%b reg=%b ang=%h expected 1 01 06de04ac",
                     busy, region, angle_red);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({ready, busy, region, angle_red, range_error} !== 37'h0) begin
            errors++;
            $display("FAIL reset_classify: got rdy=%b busy=%b reg=%b ang=%h err=%b, expected all 0",
                     ready, busy, region, angle_red, range_error);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({ready, busy} !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_idle: got rdy=%b busy=%b expected 0 0", ready, busy);
        end
    endtask

    initial begin
        int lat;
        test_reset();
        test_vectors();
        test_beg_while_busy();
        test_ready_hold();
        do_ack();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_ack: got %b expected 0", ready);
        end
        start(32'h08000000);
        wait_ready(lat);
        test_beg_ack_together();
        test_reset_in_classify();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cordic_range_reduction.md
# cordic_range_reduction

Upstream stage of the CORDIC sine/cosine datapath. Accepts a signed fixed-point angle and folds it into [0, 2π). It then classifies the angle into one of four quarter-turn regions and emits the reduced angle in [0, π/2). The region goes out as `shift_region_flag` to the CORDIC control FSM, and the reduced angle goes to the Z-input register. It uses a beg/ready/ack handshake matching the rest of the CORDIC control path.

## Interface
- `W`, default 32: angle width. Fixed format Q4.28, two's complement, radians; only W=32 is supported.
- `MAX_WRAP`, default 4: maximum number of ±2π corrections before the block declares a range error (1..15).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `beg_range_red`  in  1  start pulse; sampled only in IDLE.
- `ack_range_red`  in  1  consumer has taken the result; sampled only in DONE.
- `angle_in`  in  W  input angle, captured on the start cycle.
- `ready_range_red`  out  1  result valid; held until ack.
- `busy_range_red`  out  1  high in every state except IDLE.
- `shift_region_flag`  out  2  00 = [0,π/2), 01 = [π/2,π), 10 = [π,3π/2), 11 = [3π/2,2π).
- `angle_red`  out  W  reduced angle, in [0, π/2).
- `range_error`  out  1  set when reduction failed; qualified by ready.

## Operation
- Constants in Q4.28: HALF_PI = 0x1921FB54, PI = 0x3243F6A9, THREE_HALF_PI = 0x4B65F1FD, TWO_PI = 0x6487ED51.
- States: IDLE, WRAP, CLASSIFY, DONE.
- IDLE
  - When beg=1: latch `angle_in` into the accumulator `acc`, clear `wrap_cnt` and `range_error`, go to WRAP.
  - When beg=0: stay in IDLE.
- WRAP: evaluated once per cycle.
  - acc<0: acc += TWO_PI, wrap_cnt++.
  - acc ≥ TWO_PI: acc −= TWO_PI, wrap_cnt++.
  - Otherwise: go to CLASSIFY.
  - If acc is still out of range and wrap_cnt == MAX_WRAP: set range_error=1, region=00, angle_red=0, go to DONE.
- CLASSIFY: single cycle. Compare acc against the region bounds with unsigned compare (acc ≥ 0 here).
  - Register `shift_region_flag`.
  - Register angle_red = acc − (0, HALF_PI, PI or THREE_HALF_PI), selected by region.
  - Go to DONE.
- DONE: `ready_range_red`=1. On ack=1 go to IDLE.
- Arithmetic:
  - `acc` is W+1 bits so that ±TWO_PI cannot overflow.
  - angle_red is truncated back to W bits; the value is always < HALF_PI.
- Boundaries:
  - An angle exactly on a region bound goes to the upper region with angle_red=0. PI gives region 10.
  - acc == TWO_PI takes one more subtraction and lands on region 00, angle_red 0.
- Simultaneous events and reset:
  - beg while busy is ignored.
  - ack outside DONE is ignored.
  - beg and ack together in DONE: ack wins and beg is dropped.
  - Outputs hold their last values in IDLE until the next CLASSIFY or error.
  - Reset at any time forces IDLE immediately.

## Timing
- Reset values: every output is 0; state is IDLE; acc and wrap_cnt are 0.
- Let beg be sampled at edge 0.
- In-range input: WRAP at edge 1, CLASSIFY at edge 2, ready high after edge 3. Latency is 3 cycles.
- Each ±2π correction adds 1 cycle. Worst case is 3 + MAX_WRAP cycles.
- ready drops the cycle after ack is sampled. The earliest next beg is accepted the cycle after that, in IDLE.
- `shift_region_flag`, `angle_red` and `range_error` are stable whenever ready=1.

## Configuration
- `CORDIC_RANGE_RED_WRAP_EN`
  - Defined: WRAP state and 2π correction are present, as described above.
  - Undefined:
    - IDLE goes straight to CLASSIFY. Latency is 2 cycles.
    - An input outside [0, TWO_PI) goes to DONE with range_error=1, region 00 and angle_red 0.
    - `wrap_cnt` and the MAX_WRAP logic are removed.

## Structure
- Shared package `cordic_pkg` holds:
  - the four angle constants;
  - the state enum;
  - the region encoding (REG_Q0..REG_Q3), which is also used by the CORDIC FSM.
- One sub-module, `cordic_region_classify`: a combinational comparator plus subtract that produces the region and reduced angle from acc. It is registered in the parent.
- The FSM, accumulator and counter live in the top module.

## Test plan
- angle_in 0x08000000 (0.5 rad) → region 00, angle_red 0x08000000, range_error 0; ready 3 cycles after beg.
- angle_in 0x20000000 (2.0 rad) → region 01, angle_red 0x06DE04AC.
- angle_in 0xF0000000 (−1.0 rad), WRAP_EN → one +2π correction, region 11, angle_red 0x0921FB54; ready after 4 cycles.
- Bound cases:
  - angle_in 0x1921FB54 → region 01, angle_red 0.
  - angle_in 0x6487ED51 → region 00, angle_red 0.
- angle_in 0x90000000 (−7.0 rad):
  - MAX_WRAP=1 → range_error 1, region 00, angle_red 0.
  - MAX_WRAP=4 → range_error 0, region 11.
- Handshake and reset:
  - beg pulsed during WRAP is ignored.
  - ready is held 5 cycles without ack, then drops 1 cycle after ack.
  - reset asserted in CLASSIFY → all outputs 0 and busy 0 immediately.
